// File: rtl/rv32i_id_stage.sv
// RV32I decode stage: register file, immediate decode, branch/jump resolution, registered decode bundle.
// Optional macro RV32I_ID_WB_BYPASS_EN makes a same-cycle write-back visible to operand reads.
module rv32i_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iw_in,
  input  logic [31:0] pc_in,
  input  logic        wb_enable_in,
  input  logic [4:0]  wb_reg_in,
  input  logic [31:0] wb_data_in,
  output logic        jump_enable,
  output logic [31:0] jump_addr,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] rs1_data_out,
  output logic [31:0] rs2_data_out,
  output logic [31:0] imm_out,
  output logic [4:0]  rd_out,
  output logic        wb_enable_out
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0] rf_q [31:0];
  logic [6:0]  opcode_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [31:0] rs1_val_s, rs2_val_s, imm_s;
  logic        known_s, writes_s, is_jal_s, is_jalr_s, br_taken_s;

  logic        sq_q, sq_d;
  logic        valid_q, valid_d, wbe_q, wbe_d;
  logic [31:0] pc_q, pc_d, iw_q, iw_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [4:0]  rd_q, rd_d;

  assign opcode_s = iw_in[6:0];
  assign rd_s     = iw_in[11:7];
  assign funct3_s = iw_in[14:12];
  assign rs1_s    = iw_in[19:15];
  assign rs2_s    = iw_in[24:20];

  assign imm_i_s = {{20{iw_in[31]}}, iw_in[31:20]};
  assign imm_s_s = {{20{iw_in[31]}}, iw_in[31:25], iw_in[11:7]};
  assign imm_b_s = {{19{iw_in[31]}}, iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
  assign imm_u_s = {iw_in[31:12], 12'h000};
  assign imm_j_s = {{11{iw_in[31]}}, iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21], 1'b0};

  // Register file write port; x0 is never written and reset does not clear contents.
  always_ff @(posedge clk) begin
    if (wb_enable_in && (wb_reg_in != 5'd0)) begin
      rf_q[wb_reg_in] <= wb_data_in;
    end
  end

  // Operand reads with x0 forced to zero and optional same-cycle write-back bypass.
  always_comb begin
    rs1_val_s = 32'h0000_0000;
    rs2_val_s = 32'h0000_0000;
    if (rs1_s == 5'd0) begin
      rs1_val_s = 32'h0000_0000;
`ifdef RV32I_ID_WB_BYPASS_EN
    end else if (wb_enable_in && (wb_reg_in == rs1_s)) begin
      rs1_val_s = wb_data_in;
`endif
    end else begin
      rs1_val_s = rf_q[rs1_s];
    end
    if (rs2_s == 5'd0) begin
      rs2_val_s = 32'h0000_0000;
`ifdef RV32I_ID_WB_BYPASS_EN
    end else if (wb_enable_in && (wb_reg_in == rs2_s)) begin
      rs2_val_s = wb_data_in;
`endif
    end else begin
      rs2_val_s = rf_q[rs2_s];
    end
  end

  // Opcode decode: immediate format, write-back intent and control-transfer class.
  always_comb begin
    imm_s      = 32'h0000_0000;
    known_s    = 1'b1;
    writes_s   = 1'b0;
    is_jal_s   = 1'b0;
    is_jalr_s  = 1'b0;
    br_taken_s = 1'b0;
    case (opcode_s)
      OP_LUI, OP_AUIPC: begin imm_s = imm_u_s; writes_s = 1'b1; end
      OP_JAL:           begin imm_s = imm_j_s; writes_s = 1'b1; is_jal_s = 1'b1; end
      OP_JALR:          begin imm_s = imm_i_s; writes_s = 1'b1; is_jalr_s = 1'b1; end
      OP_LOAD, OP_IMM:  begin imm_s = imm_i_s; writes_s = 1'b1; end
      OP_OP:            begin writes_s = 1'b1; end
      OP_STORE:         begin imm_s = imm_s_s; end
      OP_FENCE, OP_SYSTEM: begin imm_s = imm_i_s; end
      OP_BRANCH: begin
        imm_s = imm_b_s;
        case (funct3_s)
          3'b000:  br_taken_s = (rs1_val_s == rs2_val_s);
          3'b001:  br_taken_s = (rs1_val_s != rs2_val_s);
          3'b100:  br_taken_s = ($signed(rs1_val_s) <  $signed(rs2_val_s));
          3'b101:  br_taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
          3'b110:  br_taken_s = (rs1_val_s <  rs2_val_s);
          3'b111:  br_taken_s = (rs1_val_s >= rs2_val_s);
          default: br_taken_s = 1'b0;
        endcase
      end
      default: known_s = 1'b0;
    endcase
  end

  // Redirect to fetch; suppressed while the current slot is squashed.
  always_comb begin
    jump_enable = ~sq_q & (is_jal_s | is_jalr_s | br_taken_s);
    if (is_jalr_s) begin
      jump_addr = (rs1_val_s + imm_i_s) & 32'hFFFF_FFFE;
    end else if (is_jal_s) begin
      jump_addr = pc_in + imm_j_s;
    end else begin
      jump_addr = pc_in + imm_b_s;
    end
  end

  // Next bundle and squash state.
  always_comb begin
    sq_d    = 1'b1;
    valid_d = 1'b0;
    wbe_d   = 1'b0;
    pc_d    = RESET_PC;
    iw_d    = 32'h0000_0000;
    rs1_d   = 32'h0000_0000;
    rs2_d   = 32'h0000_0000;
    imm_d   = 32'h0000_0000;
    rd_d    = 5'd0;
    if (reset) begin
      sq_d = 1'b1;
    end else begin
      sq_d    = jump_enable;
      valid_d = ~sq_q & known_s;
      wbe_d   = ~sq_q & known_s & writes_s & (rd_s != 5'd0);
      pc_d    = pc_in;
      iw_d    = iw_in;
      rs1_d   = rs1_val_s;
      rs2_d   = rs2_val_s;
      imm_d   = imm_s;
      rd_d    = rd_s;
    end
  end

  // Pipeline register towards execute.
  always_ff @(posedge clk) begin
    sq_q    <= sq_d;
    valid_q <= valid_d;
    wbe_q   <= wbe_d;
    pc_q    <= pc_d;
    iw_q    <= iw_d;
    rs1_q   <= rs1_d;
    rs2_q   <= rs2_d;
    imm_q   <= imm_d;
    rd_q    <= rd_d;
  end

  assign valid_out     = valid_q;
  assign wb_enable_out = wbe_q;
  assign pc_out        = pc_q;
  assign iw_out        = iw_q;
  assign rs1_data_out  = rs1_q;
  assign rs2_data_out  = rs2_q;
  assign imm_out       = imm_q;
  assign rd_out        = rd_q;
endmodule
